phys_reg_free_list: RTL and testbench

//  Free list of physical registers for the rename stage, directly upstream of the PRF.

---
 rtl/phys_reg_free_list_pkg.sv | 18 +
 rtl/phys_reg_free_list.sv | 101 ++++++++++
 tb/tb_phys_reg_free_list.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/phys_reg_free_list_pkg.sv
// Packages shared by the rename-stage free list.
//   parameter_pkg : physical/architectural register file sizing.
//   typedef_pkg   : tag and counter types derived from that sizing.

package parameter_pkg;
    localparam int PHY_REGS  = 64;
    localparam int PHY_WIDTH = 6;
    localparam int ARCH_REGS = 32;
    // Tags ARCH_REGS..PHY_REGS-1 start out free; 0..ARCH_REGS-1 hold the reset mapping.
    localparam int FREE_REGS = PHY_REGS - ARCH_REGS;
endpackage

package typedef_pkg;
    import parameter_pkg::*;
    typedef logic [PHY_WIDTH-1:0] phy_tag_t;
    // One extra bit so a completely full list (FREE_REGS) is representable.
    typedef logic [PHY_WIDTH:0]   count_t;
endpackage

// File: rtl/phys_reg_free_list.sv
// phys_reg_free_list
//   Circular free list of physical register tags for the rename stage.
//   Hands out up to two tags per cycle, reclaims the old mapping of rd at
//   retire, and rolls the speculative read pointer back to the committed one
//   on a flush.
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   flush               discard speculative allocations
//   alloc_req[1:0]      per-slot request for a destination tag
//   alloc_grant         every requested tag is available (combinational)
//   alloc_valid[1:0]    alloc_req gated by alloc_grant
//   alloc_phy_0/1       tags offered to slot0/slot1
//   retire_valid        an instruction retires this cycle
//   retire_has_rd       the retiring instruction wrote a real rd
//   rd_phy_old_commit   previous mapping of that rd, pushed back on the list
//   free_count          speculative number of free tags
//   empty               free_count == 0

module phys_reg_free_list
    import parameter_pkg::*;
    import typedef_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic [1:0]           alloc_req,
    output logic                 alloc_grant,
    output logic [1:0]           alloc_valid,
    output logic [PHY_WIDTH-1:0] alloc_phy_0,
    output logic [PHY_WIDTH-1:0] alloc_phy_1,
    input  logic                 retire_valid,
    input  logic                 retire_has_rd,
    input  logic [PHY_WIDTH-1:0] rd_phy_old_commit,
    output logic [PHY_WIDTH:0]   free_count,
    output logic                 empty
);

    localparam count_t FREE_INIT = count_t'(FREE_REGS);

    phy_tag_t fl [PHY_REGS];
    phy_tag_t head;
    phy_tag_t commit_head;
    phy_tag_t tail;
    count_t   count;
    count_t   commit_count;

    logic [1:0] req_n;
    logic [1:0] take_n;
    count_t     take_ext;
    phy_tag_t   head_p1;
    logic       do_retire;

    assign req_n    = {1'b0, alloc_req[0]} + {1'b0, alloc_req[1]};
    assign head_p1  = head + phy_tag_t'(1);

    // All-or-nothing: a two-slot request is granted only when both tags exist.
    assign alloc_grant = (count >= {{(PHY_WIDTH-1){1'b0}}, req_n}) && !flush;
    assign alloc_valid = alloc_req & {2{alloc_grant}};
    assign take_n      = alloc_grant ? req_n : 2'd0;
    assign take_ext    = {{(PHY_WIDTH-1){1'b0}}, take_n};

    // A lone slot1 request takes the head entry, so slot1 only skips ahead
    // when slot0 is consuming fl[head].
    assign alloc_phy_0 = fl[head];
    assign alloc_phy_1 = alloc_req[0] ? fl[head_p1] : fl[head];

    // Tag 0 is the permanent x0 mapping and is never returned to the list.
    assign do_retire = retire_valid && retire_has_rd && (rd_phy_old_commit != '0);

    assign free_count = count;
    assign empty      = (count == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PHY_REGS; i++) begin
                fl[i] <= (i < FREE_REGS) ? phy_tag_t'(ARCH_REGS + i) : '0;
            end
            head         <= '0;
            commit_head  <= '0;
            tail         <= phy_tag_t'(FREE_REGS);
            count        <= FREE_INIT;
            commit_count <= FREE_INIT;
        end else begin
            // The retire push survives a flush; tail and fl never roll back.
            if (do_retire) begin
                fl[tail]    <= rd_phy_old_commit;
                tail        <= tail + phy_tag_t'(1);
                commit_head <= commit_head + phy_tag_t'(1);
            end
            if (flush) begin
                // Roll back to the committed pointer including this cycle's retire.
                head  <= commit_head + phy_tag_t'(do_retire);
                count <= commit_count;
            end else begin
                head  <= head + phy_tag_t'(take_n);
                count <= count - take_ext + count_t'(do_retire);
            end
        end
    end

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Testbench for phys_reg_free_list: directed scenarios plus a constrained
// random run, with a reference model feeding a scoreboard queue.

module tb_phys_reg_free_list;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic [1:0] alloc_req;
    logic       alloc_grant;
    logic [1:0] alloc_valid;
    logic [5:0] alloc_phy_0;
    logic [5:0] alloc_phy_1;
    logic       retire_valid;
    logic       retire_has_rd;
    logic [5:0] rd_phy_old_commit;
    logic [6:0] free_count;
    logic       empty;

    phys_reg_free_list dut (
        .clk               (clk),
        .rst               (rst),
        .flush             (flush),
        .alloc_req         (alloc_req),
        .alloc_grant       (alloc_grant),
        .alloc_valid       (alloc_valid),
        .alloc_phy_0       (alloc_phy_0),
        .alloc_phy_1       (alloc_phy_1),
        .retire_valid      (retire_valid),
        .retire_has_rd     (retire_has_rd),
        .rd_phy_old_commit (rd_phy_old_commit),
        .free_count        (free_count),
        .empty             (empty)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Reference model state
    int m_fl [64];
    int m_head, m_chead, m_tail, m_count, m_ccount;

    typedef struct {
        logic       grant;
        logic [1:0] valid;
        int         p0;
        int         p1;
        int         cnt;
        logic       emp;
    } exp_t;

    exp_t sb [$];

    logic       last_grant;
    logic [5:0] last_phy0;
    logic [5:0] last_phy1;

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_fl[i] = (i < 32) ? 32 + i : -1;
        m_head = 0; m_chead = 0; m_tail = 32; m_count = 32; m_ccount = 32;
    endtask

    task automatic do_reset(input logic [1:0] req);
        @(negedge clk);
        rst = 1'b1; alloc_req = req; flush = 1'b0;
        retire_valid = 1'b0; retire_has_rd = 1'b0; rd_phy_old_commit = '0;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        rst = 1'b0; alloc_req = 2'b00;
    endtask

    // One clock: drive, predict, compare, then advance the model at the edge.
    task automatic cycle(input logic [1:0] req, input logic rv, input logic rhd,
                         input logic [5:0] old, input logic fls);
        exp_t e, o;
        int   n;
        int   ret;
        @(negedge clk);
        alloc_req = req; retire_valid = rv; retire_has_rd = rhd;
        rd_phy_old_commit = old; flush = fls;
        #1;
        n       = int'(req[0]) + int'(req[1]);
        e.grant = (m_count >= n) && !fls;
        e.valid = req & {2{e.grant}};
        e.p0    = m_fl[m_head];
        e.p1    = req[0] ? m_fl[(m_head + 1) % 64] : m_fl[m_head];
        e.cnt   = m_count;
        e.emp   = (m_count == 0);
        sb.push_back(e);
        o = sb.pop_front();
        chk("grant", alloc_grant, o.grant);
        chk("valid", alloc_valid, o.valid);
        if (o.p0 >= 0) chk("phy0", alloc_phy_0, o.p0);
        if (o.p1 >= 0) chk("phy1", alloc_phy_1, o.p1);
        chk("count", free_count, o.cnt);
        chk("empty", empty, o.emp);
        chk("count_le_max", free_count <= 7'd32, 1);
        last_grant = alloc_grant; last_phy0 = alloc_phy_0; last_phy1 = alloc_phy_1;
        @(posedge clk);
        ret = (rv && rhd && old != 0) ? 1 : 0;
        if (ret != 0) begin
            m_fl[m_tail] = int'(old);
            m_tail  = (m_tail + 1) % 64;
            m_chead = (m_chead + 1) % 64;
        end
        if (fls) begin
            m_head  = m_chead;
            m_count = m_ccount;
        end else begin
            if (e.grant) begin
                m_head  = (m_head + n) % 64;
                m_count = m_count - n;
            end
            m_count = m_count + ret;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; alloc_req = 2'b00;
        retire_valid = 1'b0; retire_has_rd = 1'b0; rd_phy_old_commit = '0;

        // Reset state and first dual allocation
        do_reset(2'b00);
        #1;
        chk("rst_count", free_count, 32);
        chk("rst_empty", empty, 0);
        chk("rst_valid", alloc_valid, 0);
        cycle(2'b11, 0, 0, 0, 0);
        chk("t1_grant", last_grant, 1);
        chk("t1_phy0", last_phy0, 32);
        chk("t1_phy1", last_phy1, 33);
        #1;
        chk("t1_count", free_count, 30);
        chk("t1_head0", alloc_phy_0, 34);
        chk("t1_head1", alloc_phy_1, 35);

        // Drain to empty, then stall
        do_reset(2'b00);
        for (int i = 0; i < 16; i++) cycle(2'b11, 0, 0, 0, 0);
        cycle(2'b01, 0, 0, 0, 0);
        chk("t2_grant", last_grant, 0);
        #1;
        chk("t2_count", free_count, 0);
        chk("t2_empty", empty, 1);
        chk("t2_valid", alloc_valid, 0);

        // Refill one tag from empty
        cycle(2'b00, 1, 1, 6'd5, 0);
        #1;
        chk("t3_count", free_count, 1);
        cycle(2'b11, 0, 0, 0, 0);
        chk("t3_grant2", last_grant, 0);
        cycle(2'b01, 0, 0, 0, 0);
        chk("t3_grant1", last_grant, 1);
        chk("t3_phy0", last_phy0, 5);

        // Flush rolls back speculative allocations
        do_reset(2'b00);
        for (int i = 0; i < 3; i++) cycle(2'b11, 0, 0, 0, 0);
        cycle(2'b00, 0, 0, 0, 1);
        #1;
        chk("t4_count", free_count, 32);
        chk("t4_phy0", alloc_phy_0, 32);

        // Retire coinciding with flush
        do_reset(2'b00);
        cycle(2'b01, 0, 0, 0, 0);
        chk("t5_a0", last_phy0, 32);
        cycle(2'b01, 0, 0, 0, 0);
        chk("t5_a1", last_phy0, 33);
        cycle(2'b00, 1, 1, 6'd7, 1);
        #1;
        chk("t5_count", free_count, 32);
        chk("t5_phy0", alloc_phy_0, 33);

        // Non-reclaiming retires and mid-sequence reset
        do_reset(2'b00);
        cycle(2'b01, 0, 0, 0, 0);
        cycle(2'b00, 1, 1, 6'd0, 0);
        #1;
        chk("t6_old0", free_count, 31);
        cycle(2'b00, 1, 0, 6'd9, 0);
        #1;
        chk("t6_nord", free_count, 31);
        cycle(2'b11, 0, 0, 0, 0);
        do_reset(2'b11);
        #1;
        chk("t6_rst_count", free_count, 32);
        chk("t6_rst_phy0", alloc_phy_0, 32);

        // Constrained random traffic; retire only while uncommitted tags exist
        do_reset(2'b00);
        for (int i = 0; i < 600; i++) begin
            logic [1:0] rq;
            logic       rv, rhd, fl_b;
            logic [5:0] old;
            rq   = 2'($urandom_range(0, 3));
            rv   = (m_count < 32) && ($urandom_range(0, 2) != 0);
            rhd  = ($urandom_range(0, 5) != 0);
            old  = 6'($urandom_range(0, 63));
            fl_b = ($urandom_range(0, 19) == 0);
            cycle(rq, rv, rhd, old, fl_b);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
